circle_tick_gen: RTL

- Upstream stage of the walking-circle display animation: generates the one-cycle step pulse that drives the walker's overflow_i input.
- User control from raw push buttons:
  - speed up / speed down;
  - pause/resume toggle;
  - single step while paused.
- Button conditioning is internal: synchronise, debounce, rising-edge detect.

---
 rtl/circle_pkg.sv | 16 +
 rtl/btn_conditioner.sv | 59 +++++
 rtl/circle_tick_gen.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/circle_pkg.sv
// circle_pkg: shared types and helpers for the walking-circle step generator.
//   state_t   : step FSM states (RUN counts periods, PAUSED waits for steps).
//   period_of : step period in clk cycles for a given speed level.
package circle_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } state_t;

  // Each speed level halves the step period of the level below it.
  function automatic int unsigned period_of(input int unsigned base, input int unsigned lvl);
    return base >> lvl;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// btn_conditioner: turns one raw asynchronous push button into a clean,
// single-cycle press pulse (synchronise, debounce, rising-edge detect).
// Ports:
//   clk_i   : system clock
//   rst_i   : synchronous active-high reset
//   raw_i   : raw button level, active-high, asynchronous to clk_i
//   press_o : one-cycle pulse, registered, on each accepted press
// Latency from the first clk edge that samples a stable high to the cycle
// press_o is high is DEBOUNCE_CYCLES+2 edges (the pulse occupies the
// DEBOUNCE_CYCLES+3-th cycle). Releases produce no pulse.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic press_o
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_r;
  logic            sync2_r;
  logic            stable_r;
  logic            prev_r;
  logic            press_r;
  logic [DB_W-1:0] db_cnt_r;

  // Synchroniser, debounce counter and rising-edge pulse register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      stable_r <= 1'b0;
      prev_r   <= 1'b0;
      press_r  <= 1'b0;
      db_cnt_r <= {DB_W{1'b0}};
    end else begin
      sync1_r <= raw_i;
      sync2_r <= sync1_r;
      // The counter measures how long the synced level has disagreed with
      // the accepted level; any agreement restarts the measurement.
      if (sync2_r == stable_r) begin
        db_cnt_r <= {DB_W{1'b0}};
      end else if (db_cnt_r == DB_LAST) begin
        stable_r <= ~stable_r;
        db_cnt_r <= {DB_W{1'b0}};
      end else begin
        db_cnt_r <= db_cnt_r + DB_W'(1'b1);
      end
      prev_r  <= stable_r;
      press_r <= stable_r & ~prev_r;
    end
  end

  assign press_o = press_r;

endmodule

// File: rtl/circle_tick_gen.sv
// circle_tick_gen: step pulse generator for the walking-circle animation.
// Produces a one-cycle overflow_o pulse every (BASE_PERIOD >> level) cycles
// while running; buttons change speed, toggle pause and single-step.
// Ports:
//   clk_i         : system clock
//   rst_i         : synchronous active-high reset
//   btn_up_i      : raw button, faster (level+1, saturating)
//   btn_down_i    : raw button, slower (level-1, saturating)
//   btn_pause_i   : raw button, toggle RUN/PAUSED
//   btn_step_i    : raw button, one step pulse while PAUSED
//   overflow_o    : registered one-cycle step pulse to the walker
//   speed_level_o : current speed level
//   paused_o      : registered, high while PAUSED
module circle_tick_gen #(
  parameter int unsigned BASE_PERIOD     = 25_000_000,
  parameter int unsigned NUM_LEVELS      = 8,
  parameter int unsigned RESET_LEVEL     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned CNT_W           = $clog2(BASE_PERIOD),
  parameter int unsigned LVL_W           = $clog2(NUM_LEVELS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             btn_up_i,
  input  logic             btn_down_i,
  input  logic             btn_pause_i,
  input  logic             btn_step_i,
  output logic             overflow_o,
  output logic [LVL_W-1:0] speed_level_o,
  output logic             paused_o
);

  import circle_pkg::*;

  localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(NUM_LEVELS - 1);
  localparam logic [LVL_W-1:0] LVL_RESET = LVL_W'(RESET_LEVEL);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic [LVL_W-1:0] level_r;
  logic [LVL_W-1:0] level_s;
  logic             ovf_r;
  logic             ovf_s;
  logic             paused_r;
  logic             press_up_s;
  logic             press_down_s;
  logic             press_pause_s;
  logic             press_step_s;
  logic             up_s;
  logic             down_s;
  logic             lvl_chg_s;
  logic             term_s;
  logic [CNT_W-1:0] term_tbl [NUM_LEVELS];

  // Terminal counts are elaboration-time constants, one per level.
  for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_term
    assign term_tbl[g] = CNT_W'(period_of(BASE_PERIOD, g) - 32'd1);
  end

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_up (
    .clk_i(clk_i), .rst_i(rst_i), .raw_i(btn_up_i), .press_o(press_up_s)
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_down (
    .clk_i(clk_i), .rst_i(rst_i), .raw_i(btn_down_i), .press_o(press_down_s)
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_pause (
    .clk_i(clk_i), .rst_i(rst_i), .raw_i(btn_pause_i), .press_o(press_pause_s)
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_step (
    .clk_i(clk_i), .rst_i(rst_i), .raw_i(btn_step_i), .press_o(press_step_s)
  );

  assign term_s    = (cnt_r == term_tbl[level_r]);
  assign lvl_chg_s = (level_s != level_r);

  // Next speed level; simultaneous up and down cancel each other
  always_comb begin
    up_s   = press_up_s & ~press_down_s;
    down_s = press_down_s & ~press_up_s;
    if (up_s && (level_r != LVL_MAX)) begin
      level_s = level_r + LVL_W'(1'b1);
    end else if (down_s && (level_r != {LVL_W{1'b0}})) begin
      level_s = level_r - LVL_W'(1'b1);
    end else begin
      level_s = level_r;
    end
  end

  // Step FSM next state, period counter and pulse request
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    ovf_s   = 1'b0;
    case (state_r)
      RUN: begin
        // A terminal count coinciding with a pause press still emits its pulse.
        ovf_s = term_s;
        if (press_pause_s) begin
          state_s = PAUSED;
          cnt_s   = CNT_ZERO;
        end else if (term_s || lvl_chg_s) begin
          cnt_s = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_W'(1'b1);
        end
      end
      PAUSED: begin
        cnt_s = CNT_ZERO;
        // Pause wins over a simultaneous step press.
        if (press_pause_s) begin
          state_s = RUN;
        end else begin
          ovf_s = press_step_s;
        end
      end
      default: begin
        state_s = RUN;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter, level and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= RUN;
      cnt_r    <= CNT_ZERO;
      level_r  <= LVL_RESET;
      ovf_r    <= 1'b0;
      paused_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      level_r  <= level_s;
      ovf_r    <= ovf_s;
      paused_r <= (state_s == PAUSED);
    end
  end

  assign overflow_o    = ovf_r;
  assign speed_level_o = level_r;
  assign paused_o      = paused_r;

endmodule
